// File: rtl/pulse_sequencer_pkg.sv
// Shared definitions for the pulse sequencer.
// Holds the FSM state encoding, the timer width and the packed layout of one
// event-table entry: {last, out[OUT_W-1:0], time[TIME_W-1:0]}.
package pulse_sequencer_pkg;

    localparam int TIME_W = 64;
    localparam int LAST_W = 1;
    localparam int STATE_W = 3;

    localparam int ENTRY_TIME_LSB = 0;
    localparam int ENTRY_OUT_LSB  = TIME_W;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_LOAD   = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT   = 3'd2;
    localparam logic [STATE_W-1:0] S_FIRE   = 3'd3;
    localparam logic [STATE_W-1:0] S_FINISH = 3'd4;

    // Total bits of one packed table entry for a given TTL word width.
    function automatic int entry_w(input int out_w);
        return LAST_W + out_w + TIME_W;
    endfunction

endpackage

// File: rtl/pulse_sequencer_if.sv
// Control/status bundle of the pulse sequencer.
//   cfg_we/cfg_addr/cfg_time/cfg_out/cfg_last : event-table write port
//   arm/abort                                 : sequence start/stop pulses
//   busy/done/ttl_out/event_strobe/event_idx/err_late : sequencer status
// master = controller driving the sequencer, slave = the sequencer itself.
interface pulse_sequencer_if #(
    parameter int DEPTH = 16,
    parameter int OUT_W = 8
) ();
    import pulse_sequencer_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);

    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [TIME_W-1:0] cfg_time;
    logic [OUT_W-1:0]  cfg_out;
    logic              cfg_last;
    logic              arm;
    logic              abort;

    logic              busy;
    logic              done;
    logic [OUT_W-1:0]  ttl_out;
    logic              event_strobe;
    logic [ADDR_W-1:0] event_idx;
    logic              err_late;

    modport master (
        output cfg_we, cfg_addr, cfg_time, cfg_out, cfg_last, arm, abort,
        input  busy, done, ttl_out, event_strobe, event_idx, err_late
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_time, cfg_out, cfg_last, arm, abort,
        output busy, done, ttl_out, event_strobe, event_idx, err_late
    );

endinterface

// File: rtl/pulse_table.sv
// Event-table storage: DEPTH entries of WIDTH bits.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata registered read
// (rdata reflects mem[raddr] one clock after raddr is presented).
// The array is deliberately not reset so it maps onto plain RAM.
module pulse_table #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 73,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pulse_sequencer.sv
// Pulse sequencer: plays a programmed event table against the ns_timer count.
// Ports: clk, reset (synchronous, active high), time_elaps (64-bit ns count),
// bus (slave side of pulse_sequencer_if: table writes, arm/abort, status and
// the registered TTL output word).
// After arm the time of the arm edge becomes t0; each entry fires once
// time_elaps - t0 (mod 2^64) reaches its offset.
module pulse_sequencer
    import pulse_sequencer_pkg::*;
#(
    parameter int               DEPTH       = 16,
    parameter int               OUT_W       = 8,
    parameter logic [OUT_W-1:0] IDLE_LEVEL  = '0,
    parameter int               LATE_TOL_NS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TIME_W-1:0] time_elaps,
    pulse_sequencer_if.slave  bus
);

    localparam int                ADDR_W    = $clog2(DEPTH);
    localparam int                ENTRY_W   = entry_w(OUT_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [TIME_W-1:0] LATE_TOL  = TIME_W'(LATE_TOL_NS);

    logic [STATE_W-1:0] state;
    logic [ADDR_W-1:0]  ptr;
    logic [TIME_W-1:0]  t0;
    logic               first_wait;

    logic               table_we;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] entry;
    logic [TIME_W-1:0]  entry_time;
    logic [OUT_W-1:0]   entry_out;
    logic               entry_last;

    logic [TIME_W-1:0]  elapsed;
    logic [TIME_W-1:0]  lateness;
    logic               due;
    logic               late;

    // The table is frozen while a sequence runs.
    assign table_we = bus.cfg_we && (state == S_IDLE);
    assign wr_entry = {bus.cfg_last, bus.cfg_out, bus.cfg_time};

    pulse_table #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_table (
        .clk   (clk),
        .we    (table_we),
        .waddr (bus.cfg_addr),
        .wdata (wr_entry),
        .raddr (ptr),
        .rdata (entry)
    );

    assign entry_time = entry[ENTRY_TIME_LSB +: TIME_W];
    assign entry_out  = entry[ENTRY_OUT_LSB +: OUT_W];
    assign entry_last = entry[ENTRY_W-1];

    // Modulo-2^64 subtraction makes a timer wrap between arm and fire invisible.
    assign elapsed  = time_elaps - t0;
    assign due      = (elapsed >= entry_time);
    // lateness is only meaningful once due, otherwise it would be a wrapped huge value.
    assign lateness = elapsed - entry_time;
    assign late     = due && (lateness > LATE_TOL);

    // Abort outranks everything else, including a fire in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            ptr              <= '0;
            t0               <= '0;
            first_wait       <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.event_strobe <= 1'b0;
            bus.event_idx    <= '0;
            bus.err_late     <= 1'b0;
            bus.ttl_out      <= IDLE_LEVEL;
        end else begin
            bus.done         <= 1'b0;
            bus.event_strobe <= 1'b0;
            if ((state != S_IDLE) && bus.abort) begin
                state       <= S_IDLE;
                bus.busy    <= 1'b0;
                bus.ttl_out <= IDLE_LEVEL;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.arm && !bus.abort) begin
                            t0           <= time_elaps;
                            ptr          <= '0;
                            bus.err_late <= 1'b0;
                            bus.busy     <= 1'b1;
                            state        <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        first_wait <= 1'b1;
                        state      <= S_WAIT;
                    end
                    S_WAIT: begin
                        first_wait <= 1'b0;
                        if (first_wait && late) begin
                            bus.err_late <= 1'b1;
                        end
                        if (due) begin
                            state <= S_FIRE;
                        end
                    end
                    S_FIRE: begin
                        bus.ttl_out      <= entry_out;
                        bus.event_strobe <= 1'b1;
                        bus.event_idx    <= ptr;
                        if (entry_last || (ptr == LAST_ADDR)) begin
                            state <= S_FINISH;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= S_LOAD;
                        end
                    end
                    S_FINISH: begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Testbench for pulse_sequencer.
// Expected strobes/done pulses are pushed into a scoreboard when a sequence is
// armed; a monitor on the falling edge pops and compares them as the DUT
// produces them. Expectations come from a timing model of the table rules
// (elapsed = 5 ns per clock since the arm edge).
module tb_pulse_sequencer;
    import pulse_sequencer_pkg::*;

    localparam int DEPTH  = 16;
    localparam int OUT_W  = 8;
    localparam int ADDR_W = 4;
    localparam int TOL    = 10;
    localparam logic [OUT_W-1:0] IDLE = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] time_elaps;

    pulse_sequencer_if #(.DEPTH(DEPTH), .OUT_W(OUT_W)) bus ();

    pulse_sequencer #(
        .DEPTH       (DEPTH),
        .OUT_W       (OUT_W),
        .IDLE_LEVEL  (IDLE),
        .LATE_TOL_NS (TOL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .time_elaps (time_elaps),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k it holds k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Timer model of ns_timer: +5 per clock, with an optional one-shot preset.
    logic [63:0] preset_val = 64'd0;
    int          preset_gen = 0;
    int          preset_seen = 0;
    initial begin
        time_elaps = 64'd0;
        forever begin
            @(negedge clk);
            if (preset_gen != preset_seen) begin
                time_elaps  = preset_val;
                preset_seen = preset_gen;
            end else begin
                time_elaps = time_elaps + 64'd5;
            end
        end
    end

    typedef struct {
        int              edge_n;
        bit              is_done;
        int              idx;
        logic [OUT_W-1:0] out;
    } exp_t;

    exp_t sb[$];
    exp_t got;

    int checks = 0;
    int errors = 0;

    logic [63:0]      m_time [DEPTH];
    logic [OUT_W-1:0] m_out  [DEPTH];
    bit               m_last [DEPTH];

    task automatic report_fail(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every strobe/done is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.event_strobe) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    report_fail("unexpected_strobe", {60'd0, bus.event_idx}, 64'd0);
                end else begin
                    got = sb.pop_front();
                    checkOutput("strobe_cycle", 64'(cyc), 64'(got.edge_n));
                    checkOutput("event_idx", 64'(bus.event_idx), 64'(got.idx));
                    checkOutput("ttl_out", 64'(bus.ttl_out), 64'(got.out));
                end
            end
            if (bus.done) begin
                if (sb.size() == 0 || !sb[0].is_done) begin
                    report_fail("unexpected_done", 64'd1, 64'd0);
                end else begin
                    got = sb.pop_front();
                    checkOutput("done_cycle", 64'(cyc), 64'(got.edge_n));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the write edge.
    task automatic writeEntry(input int addr, input int t, input logic [OUT_W-1:0] o, input bit last);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = ADDR_W'(addr);
        bus.cfg_time = 64'(t);
        bus.cfg_out  = o;
        bus.cfg_last = last;
        m_time[addr] = 64'(t);
        m_out[addr]  = o;
        m_last[addr] = last;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    // Arms the sequencer, predicts its response and runs it to completion.
    // abort_ns < 0 means no abort; poke writes the table and re-arms mid-run.
    task automatic applyStimulus(input logic [63:0] preset, input int abort_ns, input bit poke);
        int a, b, w, e, t, el, ready, end_edge, last_edge;
        bit exp_late, stop;
        a = cyc + 1;
        bus.arm = 1'b1;
        preset_val = preset;
        preset_gen++;
        b = (abort_ns >= 0) ? a + abort_ns / 5 : 32'h7fffffff;
        exp_late = 1'b0;
        stop = 1'b0;
        w = a + 2;
        last_edge = a;
        for (int i = 0; i < DEPTH; i++) begin
            if (!stop) begin
                t = int'(m_time[i]);
                ready = a + (t + 4) / 5;
                e = (ready > w) ? ready : w;
                el = 5 * (w - a);
                if (w < b && el >= t && el - t > TOL) exp_late = 1'b1;
                if (e + 1 < b) sb.push_back('{edge_n: e + 1, is_done: 1'b0, idx: i, out: m_out[i]});
                last_edge = e + 1;
                if (m_last[i] || i == DEPTH - 1) begin
                    if (e + 2 < b) sb.push_back('{edge_n: e + 2, is_done: 1'b1, idx: 0, out: '0});
                    last_edge = e + 2;
                    stop = 1'b1;
                end
                w = e + 3;
            end
        end
        end_edge = ((last_edge < b) ? last_edge : b) + 3;

        @(posedge clk);
        #1;
        bus.arm = 1'b0;
        checkOutput("busy_after_arm", 64'(bus.busy), 64'd1);
        checkOutput("late_cleared_on_arm", 64'(bus.err_late), 64'd0);
        while (cyc < end_edge) begin
            bus.abort = (abort_ns >= 0 && cyc == b - 1);
            if (poke && cyc == a + 3) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = ADDR_W'(1);
                bus.cfg_time = 64'd5;
                bus.cfg_out  = 8'hFF;
                bus.cfg_last = 1'b1;
                bus.arm      = 1'b1;
            end else begin
                bus.cfg_we = 1'b0;
                bus.arm    = 1'b0;
            end
            @(posedge clk);
            #1;
            if (abort_ns >= 0 && cyc == b) begin
                checkOutput("abort_ttl", 64'(bus.ttl_out), 64'(IDLE));
                checkOutput("abort_busy", 64'(bus.busy), 64'd0);
            end
        end
        bus.abort  = 1'b0;
        bus.cfg_we = 1'b0;
        bus.arm    = 1'b0;
        checkOutput("end_busy", 64'(bus.busy), 64'd0);
        checkOutput("err_late", 64'(bus.err_late), 64'(exp_late));
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        int n, t;
        reset        = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_time = '0;
        bus.cfg_out  = '0;
        bus.cfg_last = 1'b0;
        bus.arm      = 1'b0;
        bus.abort    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ttl", 64'(bus.ttl_out), 64'(IDLE));
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_err_late", 64'(bus.err_late), 64'd0);
        checkOutput("reset_strobe", 64'(bus.event_strobe), 64'd0);
        checkOutput("reset_idx", 64'(bus.event_idx), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single entry armed at 1000");
        writeEntry(0, 100, 8'h01, 1'b1);
        applyStimulus(64'd1000, -1, 1'b0);

        $display("[TB] three entries with write and arm while busy");
        writeEntry(0, 50, 8'h01, 1'b0);
        writeEntry(1, 200, 8'h03, 1'b0);
        writeEntry(2, 400, 8'h00, 1'b1);
        applyStimulus(64'd0, -1, 1'b1);
        $display("[TB] rerun to confirm table unchanged");
        applyStimulus(64'd0, -1, 1'b0);

        $display("[TB] abort at elapsed 250");
        applyStimulus(64'd0, 250, 1'b0);

        $display("[TB] late second entry");
        writeEntry(0, 0, 8'h01, 1'b0);
        writeEntry(1, 5, 8'h02, 1'b1);
        applyStimulus(64'd12345, -1, 1'b0);

        $display("[TB] timer wrap");
        writeEntry(0, 50, 8'h05, 1'b1);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFEC, -1, 1'b0);

        $display("[TB] full table without last flag");
        for (int i = 0; i < DEPTH; i++) begin
            writeEntry(i, i * 20, 8'(i + 8'h10), 1'b0);
        end
        applyStimulus(64'd777, -1, 1'b0);

        $display("[TB] random sequences");
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 5);
            t = 0;
            for (int i = 0; i < n; i++) begin
                t = t + $urandom_range(0, 80);
                writeEntry(i, t, 8'($urandom), (i == n - 1));
            end
            applyStimulus({$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? $urandom_range(20, 200) : -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Downstream consumer of the ns_timer free-running 64-bit nanosecond count (time_elaps). It holds a small programmable event table and, once armed, drives the spectrometer TTL/gate lines (RF gate, transmit blank, receiver gate, ADC trigger) at programmed offsets from the arm instant. It sits between ns_timer and the RF/acquisition front end on the same 200 MHz clock, where ns_timer advances 5 per cycle.

Parameters:
DEPTH, 16, number of event-table entries (power of 2, 2..256)
OUT_W, 8, width of the TTL output word
IDLE_LEVEL, 8'h00, value driven on ttl_out when not running or after abort
LATE_TOL_NS, 10, allowed firing lateness in ns before err_late is set

Ports:
clk  in  1  system clock, same as ns_timer
reset  in  1  synchronous, active-high reset
time_elaps  in  64  ns_timer count, unsigned ns
cfg_we  in  1  table write strobe
cfg_addr  in  log2(DEPTH)  table write address
cfg_time  in  64  event offset in ns from arm instant
cfg_out  in  OUT_W  TTL word applied at that event
cfg_last  in  1  marks final entry of the sequence
arm  in  1  start-sequence pulse
abort  in  1  stop-sequence pulse
busy  out  1  high from arm acceptance until done/abort
done  out  1  one-cycle pulse after the last event fires
ttl_out  out  OUT_W  registered TTL outputs
event_strobe  out  1  one-cycle pulse when an entry fires
event_idx  out  log2(DEPTH)  index of the entry just fired, valid with event_strobe
err_late  out  1  sticky lateness flag, cleared on arm acceptance or reset

Behaviour:
- Reset: state IDLE, busy=0, done=0, event_strobe=0, event_idx=0, err_late=0, ttl_out=IDLE_LEVEL, entry pointer=0, t0=0. Table contents are not reset.
- Table writes: accepted only in IDLE. When busy=1, cfg_we is ignored and the table is unchanged.
- States: IDLE, LOAD, WAIT, FIRE, FINISH.
- IDLE -> LOAD: on arm=1 with abort=0. On that edge: latch t0=time_elaps, pointer=0, err_late=0, busy=1.
- LOAD: registered table read of the entry at pointer. Takes one cycle, then -> WAIT.
- WAIT: elapsed = time_elaps - t0, computed as 64-bit unsigned modulo 2^64 so timer wrap is transparent.
  - If elapsed >= entry_time, -> FIRE.
  - On the first WAIT cycle for an entry, if elapsed - entry_time > LATE_TOL_NS, set err_late.
- FIRE, one cycle:
  - ttl_out <= entry_out, event_strobe=1, event_idx=pointer.
  - If entry_last or pointer==DEPTH-1, -> FINISH. Otherwise pointer+1 and -> LOAD.
- FINISH: done=1 for one cycle, busy<=0, -> IDLE. ttl_out holds the last entry's word.
- Latency:
  - ttl_out changes 2 clocks after the first cycle in which the time_elaps sample satisfies the compare (one cycle to leave WAIT, one to register in FIRE).
  - Minimum spacing between consecutive events is 3 cycles (15 ns). Entries closer than that fire late, in order; none are skipped.
- Entry times must be nondecreasing. A smaller time fires immediately on reaching WAIT and is flagged late if past tolerance.
- abort (any state other than IDLE): next edge -> IDLE, busy=0, ttl_out=IDLE_LEVEL, no done, no event_strobe. abort has priority over arm and over a simultaneous fire.
- arm while busy: ignored.
- reset mid-sequence: identical to power-on reset.

Decomposition:
- Shared package/include holds:
  - state encoding constants (IDLE, LOAD, WAIT, FIRE, FINISH)
  - TIME_W=64
  - entry field widths and the packed entry layout {last, out[OUT_W-1:0], time[63:0]}
- One sub-module: pulse_table. DEPTH x (65+OUT_W) storage, synchronous write, registered read, no reset on the array.

Test Plan:
- Reset held 3 cycles -> ttl_out=8'h00, busy=0, done=0, err_late=0. A cfg write while busy (mid-sequence) leaves the table unchanged; verify by reading back via a second run.
- Single entry {time=100, out=8'h01, last}; arm when time_elaps=1000 -> ttl_out=8'h01 exactly 2 cycles after time_elaps first reads >=1100. event_strobe with idx 0 is on the same edge. done pulse on the next cycle, then busy=0.
- Entries {50, 8'h01}, {200, 8'h03}, {400, 8'h00, last}; arm at time_elaps=0 -> ttl_out 01/03/00 at elapsed 60/210/410 ns (+2-cycle latency), event_idx 0,1,2, err_late=0.
- Entries {0, 8'h01}, {5, 8'h02, last} -> both fire in order. Second entry is evaluated at elapsed=25 (late by 20 > 10), so err_late=1 and stays set. A re-arm clears it.
- Entries as in the three-entry case; assert abort at elapsed=250 -> next cycle ttl_out=8'h00, busy=0, no done, no third strobe.
- time_elaps preset near wrap (t0=2^64-20), entry {50, 8'h05, last} -> fires when time_elaps wraps to 30 (elapsed 50). No premature or missed fire.
